// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-select encodings, status bit positions
// and the multiply sequencer state encoding.
package alu_pkg;

  // ALU function select: [4:2] op, [1] A-invert, [0] B-invert/carry-in
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_SHL = 5'b10000;
  localparam logic [4:0] FS_SHR = 5'b10100;

  // Bit positions inside the {V,C,Z,N} status vector
  localparam int ST_V = 3;
  localparam int ST_C = 2;
  localparam int ST_Z = 1;
  localparam int ST_N = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STEP_ADD = 3'd1,
    S_STEP_SHL = 3'd2,
    S_STEP_SHR = 3'd3,
    S_DONE     = 3'd4
  } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the execute-stage ALU for
// every add and shift. Each multiplier bit costs three cycles (ADD, SHL, SHR).
// Optional build macro MUL_EARLY_EXIT_EN: finish as soon as the shifted
// multiplier becomes zero instead of always running N iterations.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = $clog2(N) + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product,
  output logic         ovf,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [4:0]   alu_fs,
  input  logic [N-1:0] alu_f,
  input  logic [3:0]   alu_status
);

  mul_state_e    state_q, state_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplr_q, mplr_d;
  logic [N-1:0]  product_q, product_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] count_q, count_d;

  // Only C (and Z in the early-exit build) matter here; V and N are ignored.
  logic          unused_status_s;
  assign unused_status_s = &{1'b0, alu_status};

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic and ALU operand/function drive for the current step
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_fs    = FS_AND;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d   = a_in;
          mplr_d    = b_in;
          product_d = '0;
          ovf_d     = 1'b0;
          count_d   = '0;
          state_d   = S_STEP_ADD;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_STEP_ADD: begin
        // Accumulate the shifted multiplicand when the current bit is set;
        // a carry out means the true product no longer fits in N bits.
        if (mplr_q[0]) begin
          alu_a     = product_q;
          alu_b     = mcand_q;
          alu_fs    = FS_ADD;
          product_d = alu_f;
          ovf_d     = ovf_q | alu_status[ST_C];
        end else begin
          product_d = product_q;
        end
        state_d = S_STEP_SHL;
      end

      S_STEP_SHL: begin
        // A set bit falling off the multiplicand matters only if some
        // later multiplier bit would still have added it in.
        alu_a   = mcand_q;
        alu_b   = N'(1);
        alu_fs  = FS_SHL;
        mcand_d = alu_f;
        ovf_d   = ovf_q | (mcand_q[N-1] & (mplr_q[N-1:1] != '0));
        state_d = S_STEP_SHR;
      end

      S_STEP_SHR: begin
        alu_a   = mplr_q;
        alu_b   = N'(1);
        alu_fs  = FS_SHR;
        mplr_d  = alu_f;
        count_d = count_q + CW'(1);
`ifdef MUL_EARLY_EXIT_EN
        if (alu_status[ST_Z] || (count_q == CW'(N - 1))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_STEP_ADD;
        end
`else
        if (count_q == CW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_STEP_ADD;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU wired to the
// alu_* ports. Expected latencies follow MUL_EARLY_EXIT_EN when defined.
module tb_alu_mul_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [63:0] a_in, b_in;
  logic        busy, done, ovf;
  logic [63:0] product;
  logic [63:0] alu_a, alu_b, alu_f;
  logic [4:0]  alu_fs;
  logic [3:0]  alu_status;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  alu_mul_sequencer #(.N(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .ovf        (ovf),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fs     (alu_fs),
    .alu_f      (alu_f),
    .alu_status (alu_status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model of the team ALU
  logic [63:0] aa, bb;
  logic [64:0] sum;
  logic        c_s, v_s;
  always_comb begin
    aa    = alu_fs[1] ? ~alu_a : alu_a;
    bb    = alu_fs[0] ? ~alu_b : alu_b;
    sum   = 65'd0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    alu_f = 64'd0;
    case (alu_fs[4:2])
      3'b000: alu_f = aa & bb;
      3'b001: alu_f = aa | bb;
      3'b010: begin
        sum   = {1'b0, aa} + {1'b0, bb} + {64'd0, alu_fs[0]};
        alu_f = sum[63:0];
        c_s   = sum[64];
        v_s   = (aa[63] == bb[63]) && (sum[63] != aa[63]);
      end
      3'b011: alu_f = aa ^ bb;
      3'b100: alu_f = alu_a << alu_b[5:0];
      3'b101: alu_f = alu_a >> alu_b[5:0];
      default: alu_f = 64'd0;
    endcase
    alu_status = {v_s, c_s, (alu_f == 64'd0), alu_f[63]};
  end

  function automatic int exp_lat(input logic [63:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < 64; i++) if (b[i]) h = i + 1;
    return (h == 0) ? 4 : 3 * h + 1;
`else
    return 3 * 64 + 1;
`endif
  endfunction

  // Present operands with start for one edge; returns sampling in cycle 1
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    @(negedge clock);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc   = 1;
  endtask

  // Step until the done pulse has passed and busy drops (bounded)
  task automatic wait_done(output int lat, output int pulses);
    lat    = 0;
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        pulses++;
        if (lat == 0) lat = cyc;
      end
      if (!busy && lat != 0) break;
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0 || ovf !== 1'b0 ||
        alu_fs !== 5'b00000 || alu_a !== 64'd0 || alu_b !== 64'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b prod=%0h ovf=%b fs=%b a=%0h b=%0h expected all zero",
               busy, done, product, ovf, alu_fs, alu_a, alu_b);
    end
  endtask

  task automatic test_basic;
    int lat, pulses;
    start_op(64'd6, 64'd7);
    checks++;
    if (alu_fs !== 5'b01000 || alu_a !== 64'd0 || alu_b !== 64'd6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_add_step got fs=%b a=%0h b=%0h busy=%b expected fs=01000 a=0 b=6 busy=1",
               alu_fs, alu_a, alu_b, busy);
    end
    @(negedge clock); cyc++;
    checks++;
    if (alu_fs !== 5'b10000 || alu_a !== 64'd6 || alu_b !== 64'd1) begin
      errors++;
      $display("FAIL basic_shl_step got fs=%b a=%0h b=%0h expected fs=10000 a=6 b=1", alu_fs, alu_a, alu_b);
    end
    @(negedge clock); cyc++;
    checks++;
    if (alu_fs !== 5'b10100 || alu_a !== 64'd7 || alu_b !== 64'd1) begin
      errors++;
      $display("FAIL basic_shr_step got fs=%b a=%0h b=%0h expected fs=10100 a=7 b=1", alu_fs, alu_a, alu_b);
    end
    wait_done(lat, pulses);
    checks++;
    if (lat !== exp_lat(64'd7) || pulses !== 1) begin
      errors++;
      $display("FAIL basic_latency got lat=%0d pulses=%0d expected lat=%0d pulses=1", lat, pulses, exp_lat(64'd7));
    end
    checks++;
    if (product !== 64'd42 || ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got prod=%0d ovf=%b busy=%b expected prod=42 ovf=0 busy=0", product, ovf, busy);
    end
  endtask

  // Run one operation and compare product, ovf and latency
  task automatic test_vector(input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] exp_p, input logic exp_o);
    int lat, pulses;
    start_op(a, b);
    wait_done(lat, pulses);
    checks++;
    if (product !== exp_p || ovf !== exp_o || lat !== exp_lat(b) || pulses !== 1) begin
      errors++;
      $display("FAIL vector a=%0h b=%0h got prod=%0h ovf=%b lat=%0d pulses=%0d expected prod=%0h ovf=%b lat=%0d pulses=1",
               a, b, product, ovf, lat, pulses, exp_p, exp_o, exp_lat(b));
    end
  endtask

  task automatic test_start_while_busy;
    int lat, pulses, extra, pulse_c;
    pulse_c = (exp_lat(64'd7) > 60) ? 50 : 5;
    start_op(64'd6, 64'd7);
    lat = 0; pulses = 0; extra = 0;
    for (int i = 0; i < 400; i++) begin
      if (cyc == pulse_c) begin
        start = 1'b1; a_in = 64'd9; b_in = 64'd9;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (lat == 0) lat = cyc;
      end
      if (!busy && lat != 0) break;
      @(negedge clock); cyc++;
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (busy || done) extra++;
    end
    checks++;
    if (product !== 64'd42 || pulses !== 1 || lat !== exp_lat(64'd7) || extra !== 0) begin
      errors++;
      $display("FAIL start_busy got prod=%0d pulses=%0d lat=%0d extra=%0d expected prod=42 pulses=1 lat=%0d extra=0",
               product, pulses, lat, extra, exp_lat(64'd7));
    end
  endtask

  task automatic test_start_in_done;
    int seen;
    seen = 0;
    start_op(64'd3, 64'd5);
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clock); cyc++;
    end
    a_in  = 64'd4;
    b_in  = 64'd4;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (seen !== 1 || busy !== 1'b0 || product !== 64'd15) begin
      errors++;
      $display("FAIL start_in_done got seen=%0d busy=%b prod=%0d expected seen=1 busy=0 prod=15", seen, busy, product);
    end
  endtask

  task automatic test_reset_midop;
    int rst_c, stray;
    rst_c = (exp_lat(64'd7) > 60) ? 100 : 5;
    start_op(64'd6, 64'd7);
    while (cyc < rst_c) begin
      @(negedge clock); cyc++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy got busy=%b expected 1", busy);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || product !== 64'd0 || ovf !== 1'b0 || alu_fs !== 5'b00000 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop got busy=%b prod=%0h ovf=%b fs=%b done=%b expected 0 0 0 00000 0",
               busy, product, ovf, alu_fs, done);
    end
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      if (done || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL reset_no_done got stray=%0d expected 0", stray);
    end
    test_vector(64'd3, 64'd5, 64'd15, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a_in  = 64'd0;
    b_in  = 64'd0;
    repeat (3) @(negedge clock);
    test_reset;
    reset = 1'b0;
    test_basic;
    test_vector(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    test_vector(64'd123, 64'd0, 64'd0, 1'b0);
    test_vector(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    test_vector(64'h8000_0000_0000_0001, 64'd3, 64'h8000_0000_0000_0003, 1'b1);
    test_vector(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    test_vector(64'd3, 64'd5, 64'd15, 1'b0);
    test_start_while_busy;
    test_start_in_done;
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
